vga_sync_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_sync_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_timing_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and shared types for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_TOTAL = 800;
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_H_FRONT = 16;
    localparam int unsigned DEF_V_TOTAL = 525;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_V_FRONT = 10;

    // Active window is [START, END) in counter units.
    localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned H_ACT_END   = DEF_H_TOTAL - DEF_H_FRONT;
    localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned V_ACT_END   = DEF_V_TOTAL - DEF_V_FRONT;

    typedef logic [9:0] cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with count enable; wrap_o flags the enabled terminal count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = 800
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output cnt_t cnt_o,
    output logic wrap_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        wrap_o = en_i && (cnt_q == cnt_t'(TOTAL - 1));
        cnt_d  = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_sync_timing_gen.sv
// Free-running VGA raster timing generator (default 640x480@60), registered HS/VS/blank_n.
// Define VGA_PIXEL_COORD_EN to add x_pos/y_pos/frame_start outputs.
module vga_sync_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter int unsigned V_FRONT = DEF_V_FRONT
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    output logic       blank_n,
    output logic       HS,
    output logic       VS
`ifdef VGA_PIXEL_COORD_EN
    ,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       frame_start
`endif
);

    localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);
    localparam cnt_t H_ACT_LO   = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_ACT_HI   = cnt_t'(H_TOTAL - H_FRONT);
    localparam cnt_t V_ACT_LO   = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_ACT_HI   = cnt_t'(V_TOTAL - V_FRONT);

    cnt_t  h_cnt;
    cnt_t  v_cnt;
    logic  h_wrap;
    logic  v_wrap_unused;
    logic  h_act;
    logic  v_act;
    sync_t sync_d;
    sync_t sync_q;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk_i  (iVGA_CLK),
        .rst_ni (iRST_n),
        .en_i   (1'b1),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    // Vertical advances only on the horizontal wrap, so both wrap on the same edge.
    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk_i  (iVGA_CLK),
        .rst_ni (iRST_n),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap_unused)
    );

    always_comb begin
        h_act          = in_window(h_cnt, H_ACT_LO, H_ACT_HI);
        v_act          = in_window(v_cnt, V_ACT_LO, V_ACT_HI);
        sync_d.hs      = ~(h_cnt < H_SYNC_END);
        sync_d.vs      = ~(v_cnt < V_SYNC_END);
        sync_d.blank_n = h_act & v_act;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            sync_q <= SYNC_IDLE;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign HS      = sync_q.hs;
    assign VS      = sync_q.vs;
    assign blank_n = sync_q.blank_n;

`ifdef VGA_PIXEL_COORD_EN
    logic [9:0] x_d;
    logic [9:0] y_d;
    logic       fs_d;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       fs_q;

    // Same registered stage as sync_q so coordinates line up with blank_n.
    always_comb begin
        x_d  = '0;
        y_d  = '0;
        fs_d = (h_cnt == H_ACT_LO) && (v_cnt == V_ACT_LO);
        if (h_act && v_act) begin
            x_d = h_cnt - H_ACT_LO;
            y_d = v_cnt - V_ACT_LO;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            x_q  <= '0;
            y_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fs_q <= fs_d;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_sync_timing_gen.sv
// Scoreboard bench: default-timing instance plus a reduced-timing instance for frame-level checks.
module tb_vga_sync_timing_gen;

    localparam int B_HT = 800, B_HS = 96, B_HB = 48, B_HF = 16;
    localparam int B_VT = 525, B_VS = 2,  B_VB = 33, B_VF = 10;
    localparam int S_HT = 40,  S_HS = 4,  S_HB = 3,  S_HF = 2;
    localparam int S_VT = 12,  S_VS = 2,  S_VB = 3,  S_VF = 1;
    localparam int RUN  = B_HT * 36;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    logic rst_s = 1'b0;
    logic hs_b, vs_b, bl_b, hs_s, vs_s, bl_s;
`ifdef VGA_PIXEL_COORD_EN
    logic [9:0] x_b, y_b, x_s, y_s;
    logic       fs_b, fs_s;
    int x_max_b = 0, y_max_b = 0, x_max_s = 0, y_max_s = 0, viol = 0, fs_cnt_s = 0;
`endif

    int   n_tests = 0, n_fail = 0;
    exp_t q_b[$];
    exp_t q_s[$];
    int   mb_h = 0, mb_v = 0, ms_h = 0, ms_v = 0;
    logic live_b = 1'b0, live_s = 1'b0;
    int   cyc = 0;
    logic [2:0] ob, os;
    logic [2:0] prev_b = 3'b110, prev_s = 3'b110;
    int   hs_low_b = 0, vs_low_b = 0, bl_cnt_b = 0, bl_rise_b = 0;
    int   hs_fall_b = 0, vs_fall_b = -1, first_bl_b = -1, bl_off_b = -1;
    int   falls_s = 0;
    int   fall_t_s[4];
    int   bl_frame_s[3];
    int   mid_phase = 0;
    logic rs_next;

    vga_sync_timing_gen u_big (
        .iVGA_CLK (clk),
        .iRST_n   (rst_b),
        .blank_n  (bl_b),
        .HS       (hs_b),
        .VS       (vs_b)
`ifdef VGA_PIXEL_COORD_EN
        ,
        .x_pos       (x_b),
        .y_pos       (y_b),
        .frame_start (fs_b)
`endif
    );

    vga_sync_timing_gen #(
        .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_BACK(S_HB), .H_FRONT(S_HF),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_BACK(S_VB), .V_FRONT(S_VF)
    ) u_small (
        .iVGA_CLK (clk),
        .iRST_n   (rst_s),
        .blank_n  (bl_s),
        .HS       (hs_s),
        .VS       (vs_s)
`ifdef VGA_PIXEL_COORD_EN
        ,
        .x_pos       (x_s),
        .y_pos       (y_s),
        .frame_start (fs_s)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic rn, input int h, input int v,
                                   input int ht, input int hsy, input int hb, input int hf,
                                   input int vt, input int vsy, input int vb, input int vf);
        exp_t e;
        logic act;
        e = '0;
        if (!rn) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        e.hs = (h >= hsy);
        e.vs = (v >= vsy);
        act  = (h >= hsy + hb) && (h < ht - hf) && (v >= vsy + vb) && (v < vt - vf);
        e.bl = act;
        if (act) begin
            e.x = 10'(h - (hsy + hb));
            e.y = 10'(v - (vsy + vb));
        end
        e.fs = (h == hsy + hb) && (v == vsy + vb);
        return e;
    endfunction

    task automatic adv(input logic rn, input int ht, input int vt, inout int h, inout int v);
        if (!rn) begin
            h = 0;
            v = 0;
        end else if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
    endtask

    // Sample outputs of the previous edge, then drive resets and queue the next edge's result.
    task automatic step(input logic rb, input logic rs);
        exp_t e;
        @(negedge clk);
        cyc++;
        ob = {hs_b, vs_b, bl_b};
        os = {hs_s, vs_s, bl_s};
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("big_sync", 32'(ob), 32'({e.hs, e.vs, e.bl}));
`ifdef VGA_PIXEL_COORD_EN
            check("big_x", 32'(x_b), 32'(e.x));
            check("big_y", 32'(y_b), 32'(e.y));
            check("big_fs", 32'(fs_b), 32'(e.fs));
`endif
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            check("small_sync", 32'(os), 32'({e.hs, e.vs, e.bl}));
`ifdef VGA_PIXEL_COORD_EN
            check("small_x", 32'(x_s), 32'(e.x));
            check("small_y", 32'(y_s), 32'(e.y));
            check("small_fs", 32'(fs_s), 32'(e.fs));
`endif
        end
        if (live_b) begin
            if (!ob[2]) hs_low_b++;
            if (!ob[1]) vs_low_b++;
            if (ob[0]) bl_cnt_b++;
            if (prev_b[2] && !ob[2]) hs_fall_b = cyc;
            if (prev_b[1] && !ob[1] && vs_fall_b < 0) vs_fall_b = cyc;
            if (!prev_b[0] && ob[0]) begin
                bl_rise_b++;
                if (first_bl_b < 0) begin
                    first_bl_b = cyc;
                    bl_off_b   = cyc - hs_fall_b;
                end
            end
        end
        if (live_s) begin
            if (prev_s[1] && !os[1] && falls_s < 4) begin
                fall_t_s[falls_s] = cyc;
                falls_s++;
            end
            if (os[0] && falls_s >= 1 && falls_s <= 3) bl_frame_s[falls_s-1]++;
`ifdef VGA_PIXEL_COORD_EN
            if (fs_s && falls_s >= 1 && falls_s <= 3) fs_cnt_s++;
`endif
        end
`ifdef VGA_PIXEL_COORD_EN
        if (bl_s) begin
            if (int'(x_s) > x_max_s) x_max_s = int'(x_s);
            if (int'(y_s) > y_max_s) y_max_s = int'(y_s);
        end else if (x_s != 10'd0 || y_s != 10'd0) begin
            viol++;
        end
        if (bl_b) begin
            if (int'(x_b) > x_max_b) x_max_b = int'(x_b);
            if (int'(y_b) > y_max_b) y_max_b = int'(y_b);
        end else if (x_b != 10'd0 || y_b != 10'd0) begin
            viol++;
        end
`endif
        prev_b = ob;
        prev_s = os;
        rst_b  = rb;
        rst_s  = rs;
        live_b = rb;
        live_s = rs;
        q_b.push_back(model(rb, mb_h, mb_v, B_HT, B_HS, B_HB, B_HF, B_VT, B_VS, B_VB, B_VF));
        adv(rb, B_HT, B_VT, mb_h, mb_v);
        q_s.push_back(model(rs, ms_h, ms_v, S_HT, S_HS, S_HB, S_HF, S_VT, S_VS, S_VB, S_VF));
        adv(rs, S_HT, S_VT, ms_h, ms_v);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) bl_frame_s[k] = 0;
        repeat (5) step(1'b0, 1'b0);
        check("rst_hold_big", 32'({hs_b, vs_b, bl_b}), 32'h6);
        check("rst_hold_small", 32'({hs_s, vs_s, bl_s}), 32'h6);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("release_big", 32'({hs_b, vs_b}), 32'h0);
        check("release_small", 32'({hs_s, vs_s}), 32'h0);

        for (int i = 1; i < RUN; i++) begin
            rs_next = 1'b1;
            if (mid_phase == 0 && falls_s >= 4 && ms_h == 20 && ms_v == 6) begin
                rs_next   = 1'b0;
                mid_phase = 1;
            end
            step(1'b1, rs_next);
            if (mid_phase == 2) check("mid_rst_hold", 32'({hs_s, vs_s, bl_s}), 32'h6);
            if (mid_phase == 3) check("mid_rst_vs_fall", 32'({hs_s, vs_s}), 32'h0);
            if (mid_phase > 0 && mid_phase < 4) mid_phase++;
        end

        check("big_hs_low_clks", 32'(hs_low_b), 32'(36 * B_HS));
        check("big_vs_low_clks", 32'(vs_low_b), 32'(B_VS * B_HT));
        check("big_blank_clks", 32'(bl_cnt_b), 32'(640));
        check("big_blank_lines", 32'(bl_rise_b), 32'(1));
        check("big_blank_after_hs", 32'(bl_off_b), 32'(144));
        check("big_act_after_vs", 32'(first_bl_b - vs_fall_b), 32'(35 * B_HT + 144));
        check("small_vs_falls", 32'(falls_s), 32'(4));
        for (int k = 0; k < 3; k++) begin
            check("small_frame_period", 32'(fall_t_s[k+1] - fall_t_s[k]), 32'(S_HT * S_VT));
            check("small_frame_blank", 32'(bl_frame_s[k]), 32'(6 * 31));
        end
        check("mid_rst_done", 32'(mid_phase), 32'(4));
`ifdef VGA_PIXEL_COORD_EN
        check("small_fs_per_frame", 32'(fs_cnt_s), 32'(3));
        check("small_x_max", 32'(x_max_s), 32'(30));
        check("small_y_max", 32'(y_max_s), 32'(5));
        check("big_x_max", 32'(x_max_b), 32'(639));
        check("big_y_max", 32'(y_max_b), 32'(0));
        check("coord_zero_in_blank", 32'(viol), 32'(0));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
